// File: rtl/icgtn_bank_if.sv
// Bundles the per-channel enable controls and gated clock/status outputs of icgtn_bank.
// The bench drives through the master modport; the bank uses the slave modport.
interface icgtn_bank_if #(
  parameter int NCH    = 4,
  parameter int IDLE_W = 4
);
  logic              TE;
  logic [NCH-1:0]    E;
  logic [NCH-1:0]    AUTO;
  logic [IDLE_W-1:0] IDLE_CNT;
  logic [NCH-1:0]    Q;
  logic [NCH-1:0]    ACTIVE;
  logic              BUSY;

  modport master (output TE, E, AUTO, IDLE_CNT, input  Q, ACTIVE, BUSY);
  modport slave  (input  TE, E, AUTO, IDLE_CNT, output Q, ACTIVE, BUSY);
endinterface

// File: rtl/icgtn_bank.sv
// Bank of NCH negative-pulse clock gates with optional auto-idle drain; no flow control.
// Enables sampled on rising CLKN gate the low phase right after that edge.
module icgtn_bank #(
  parameter int NCH    = 4,
  parameter int IDLE_W = 4
) (
  input logic         CLKN,
  input logic         RST,
  icgtn_bank_if.slave bus
);

  typedef enum logic [1:0] {OFF, ON, DRAIN} state_t;

  state_t            state_q [NCH];
  state_t            state_d [NCH];
  logic [IDLE_W-1:0] cnt_q   [NCH];
  logic [IDLE_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]    en_q;
  logic              te_q;

  always_ff @(posedge CLKN or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= '0;
        en_q[i]    <= 1'b0;
      end
      te_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        // Enable is its own flop so Q never sees a state-decode glitch.
        en_q[i]    <= (state_d[i] != OFF);
      end
      te_q <= bus.TE;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        OFF: begin
          if (bus.E[i]) state_d[i] = ON;
        end
        ON: begin
          if (!bus.E[i]) begin
            if (bus.AUTO[i] && (bus.IDLE_CNT != '0)) begin
              state_d[i] = DRAIN;
              cnt_d[i]   = bus.IDLE_CNT - IDLE_W'(1);
            end else begin
              state_d[i] = OFF;
            end
          end
        end
        DRAIN: begin
          if (bus.E[i]) begin
            state_d[i] = ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - IDLE_W'(1);
          end
        end
        default: begin
          state_d[i] = OFF;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Enables only change while CLKN is high, so the OR cannot chop a low pulse.
  assign bus.Q      = {NCH{CLKN}} | ~(en_q | {NCH{te_q}});
  assign bus.ACTIVE = en_q;
  assign bus.BUSY   = |en_q;

endmodule

// File: tb/tb_icgtn_bank.sv
// Directed bench for icgtn_bank: per-edge stimulus rows with hand-computed gated-clock expectations.
module tb_icgtn_bank;
  localparam int NCH    = 4;
  localparam int IDLE_W = 4;

  logic CLKN = 1'b1;
  logic RST  = 1'b0;

  icgtn_bank_if #(.NCH(NCH), .IDLE_W(IDLE_W)) bus ();

  icgtn_bank #(.NCH(NCH), .IDLE_W(IDLE_W)) dut (
    .CLKN (CLKN),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 CLKN = ~CLKN;

  typedef struct {
    logic       te;
    logic       rst;
    logic [3:0] e;
    logic [3:0] au;
    logic [3:0] idle;
    logic [3:0] q;
    logic [3:0] act;
  } row_t;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] act;
    logic       busy;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  task automatic add(input logic te, input logic rst, input logic [3:0] e, input logic [3:0] au,
                     input logic [3:0] idle, input logic [3:0] q, input logic [3:0] act);
    row_t r;
    r.te = te; r.rst = rst; r.e = e; r.au = au; r.idle = idle; r.q = q; r.act = act;
    rows.push_back(r);
  endtask

  // Monitor: each low phase shows the gated pulses decided at the preceding rising edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge CLKN);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q_low",  32'(bus.Q),      32'(x.q));
        chk("active", 32'(bus.ACTIVE), 32'(x.act));
        chk("busy",   32'(bus.BUSY),   32'(x.busy));
      end
    end
  end

  // Outside reset every output clock must idle high during the CLKN high phase.
  initial begin
    forever begin
      @(posedge CLKN);
      #2;
      if (!RST) chk("q_high", 32'(bus.Q), 32'hF);
    end
  end

  initial begin
    exp_t x;
    bus.TE = 1'b0; bus.E = '0; bus.AUTO = '0; bus.IDLE_CNT = '0;

    // Row k is sampled at rising edge k and its expectation is the low phase right after.
    // Plain gating, AUTO=0 (edges 1..6)
    for (int k = 0; k < 4; k++) add(0, 0, 4'b0001, 4'b0000, 4'd0, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0000, 4'd0, 4'b1111, 4'b0000);
    add(0, 0, 4'b0000, 4'b0000, 4'd0, 4'b1111, 4'b0000);
    // Auto drain of 3, with IDLE_CNT/AUTO changes during DRAIN ignored (edges 7..14)
    for (int k = 0; k < 3; k++) add(0, 0, 4'b0001, 4'b0001, 4'd3, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0001, 4'd3, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0000, 4'd9, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0000, 4'd9, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0000, 4'd9, 4'b1111, 4'b0000);
    add(0, 0, 4'b0000, 4'b0000, 4'd9, 4'b1111, 4'b0000);
    // Re-enable inside DRAIN, then IDLE_CNT=0 behaves like AUTO=0 (edges 15..20)
    add(0, 0, 4'b0001, 4'b0001, 4'd4, 4'b1110, 4'b0001);
    add(0, 0, 4'b0001, 4'b0001, 4'd4, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0001, 4'd4, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0001, 4'd4, 4'b1110, 4'b0001);
    add(0, 0, 4'b0001, 4'b0001, 4'd4, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0001, 4'd0, 4'b1111, 4'b0000);
    // Test enable forces pulses but leaves ACTIVE to the FSMs (edges 21..27)
    for (int k = 0; k < 3; k++) add(1, 0, 4'b0000, 4'b0000, 4'd0, 4'b0000, 4'b0000);
    add(0, 0, 4'b0000, 4'b0000, 4'd0, 4'b1111, 4'b0000);
    add(1, 0, 4'b0100, 4'b0000, 4'd0, 4'b0000, 4'b0100);
    add(0, 0, 4'b0100, 4'b0000, 4'd0, 4'b1011, 4'b0100);
    add(0, 0, 4'b0000, 4'b0000, 4'd0, 4'b1111, 4'b0000);
    // Maximum drain: exactly 15 extra pulses on channel 1 (edges 28..44)
    add(0, 0, 4'b0010, 4'b0010, 4'd15, 4'b1101, 4'b0010);
    for (int k = 0; k < 15; k++) add(0, 0, 4'b0000, 4'b0010, 4'd15, 4'b1101, 4'b0010);
    add(0, 0, 4'b0000, 4'b0010, 4'd15, 4'b1111, 4'b0000);
    // Reset mid-DRAIN with cnt=2, in the low phase after edge 46 (edges 45..50)
    add(0, 0, 4'b0001, 4'b0001, 4'd3, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0001, 4'd3, 4'b1110, 4'b0001);
    add(0, 1, 4'b0000, 4'b0001, 4'd3, 4'b1111, 4'b0000);
    add(0, 0, 4'b0000, 4'b0001, 4'd3, 4'b1111, 4'b0000);
    add(0, 0, 4'b0001, 4'b0000, 4'd3, 4'b1110, 4'b0001);
    add(0, 0, 4'b0000, 4'b0000, 4'd3, 4'b1111, 4'b0000);
    // All channels, mixed AUTO with a one-pulse drain (edges 51..53)
    add(0, 0, 4'b1111, 4'b0101, 4'd1, 4'b0000, 4'b1111);
    add(0, 0, 4'b0000, 4'b0101, 4'd1, 4'b1010, 4'b0101);
    add(0, 0, 4'b0000, 4'b0101, 4'd1, 4'b1111, 4'b0000);

    RST = 1'b1;
    #1;
    chk("reset_q",      32'(bus.Q),      32'hF);
    chk("reset_active", 32'(bus.ACTIVE), 32'h0);
    chk("reset_busy",   32'(bus.BUSY),   32'h0);
    #2;
    RST = 1'b0;

    foreach (rows[j]) begin
      @(negedge CLKN);
      #2;
      if (rows[j].rst) begin
        RST = 1'b1;
        #1;
        chk("async_rst_q",      32'(bus.Q),      32'hF);
        chk("async_rst_active", 32'(bus.ACTIVE), 32'h0);
        chk("async_rst_busy",   32'(bus.BUSY),   32'h0);
        RST = 1'b0;
      end
      bus.TE       = rows[j].te;
      bus.E        = rows[j].e;
      bus.AUTO     = rows[j].au;
      bus.IDLE_CNT = rows[j].idle;
      x.q    = rows[j].q;
      x.act  = rows[j].act;
      x.busy = |rows[j].act;
      sb.push_back(x);
    end

    repeat (3) @(negedge CLKN);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icgtn_bank.md
ICGTN_BANK -- requirements
Module: icgtn_bank

Interface
REQ-001 SHALL: parameter NCH, default 4, number of independent gated-clock channels (1..16).
REQ-002 SHALL: parameter IDLE_W, default 4, width of idle hold-off count.
REQ-003 SHALL: port CLKN  input  1  source clock, negative-active (pulse = low phase); sole clock of block.
REQ-004 SHALL: port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL: port TE  input  1  test enable; forces all channel clocks on.
REQ-006 SHALL: port E  input  NCH  per-channel functional enable request.
REQ-007 SHALL: port AUTO  input  NCH  per-channel auto-idle mode select.
REQ-008 SHALL: port IDLE_CNT  input  IDLE_W  number of extra low pulses kept after E deasserts (AUTO channels).
REQ-009 SHALL: port Q  output  NCH  gated negative clocks; idle level high.
REQ-010 SHALL: port ACTIVE  output  NCH  registered per-channel enable state (state != OFF).
REQ-011 SHALL: port BUSY  output  1  OR of ACTIVE bits.

Function
REQ-012 SHALL: all state registers update on rising edge of CLKN only; nothing changes during CLKN low phase.
REQ-013 SHALL: per-channel enable en_q[i] and test enable te_q registered at rising CLKN; Q[i] = CLKN OR NOT(en_q[i] OR te_q), glitch-free since enables are stable throughout low phase.
REQ-014 SHALL: latency -- E/TE sampled at rising edge k controls the low phase immediately after edge k.
REQ-015 SHALL: per-channel FSM states OFF, ON, DRAIN; en_q[i] = 1 in ON and DRAIN.
REQ-016 SHALL: OFF -> ON when E[i]=1; else stay OFF.
REQ-017 SHALL: ON stays ON while E[i]=1; on E[i]=0: AUTO[i]=0 -> OFF; AUTO[i]=1 and IDLE_CNT=0 -> OFF; AUTO[i]=1 and IDLE_CNT>0 -> DRAIN with cnt[i] = IDLE_CNT-1.
REQ-018 SHALL: DRAIN -> ON when E[i]=1 (cnt cleared); else cnt=0 -> OFF; else cnt decrements, stay DRAIN.
REQ-019 SHALL: net effect -- AUTO channel delivers exactly IDLE_CNT extra low pulses after the first rising edge sampling E[i]=0.
REQ-020 SHALL: IDLE_CNT captured only on ON->DRAIN; changes during DRAIN ignored.
REQ-021 SHALL: AUTO[i] change during DRAIN ignored until next ON->DRAIN decision.
REQ-022 SHALL: TE=1 forces all Q to toggle regardless of FSM; FSMs keep evolving normally underneath; ACTIVE reflects FSM only, not TE.
REQ-023 SHALL: channels fully independent; counters IDLE_W wide, never wrap (decrement stops at 0).
REQ-024 SHALL: ACTIVE[i] = en_q[i]; BUSY combinational OR of ACTIVE.

Reset
REQ-025 SHALL: RST=1 asynchronously sets all FSMs OFF, cnt=0, en_q=0, te_q=0; Q all 1, ACTIVE 0, BUSY 0 immediately.
REQ-026 SHALL: reset asserted during a low phase forces Q high at once (truncated pulse accepted).
REQ-027 SHALL: after RST deasserts, first rising CLKN edge samples inputs normally; no extra warm-up cycles.

Verification
REQ-028 SHALL: NCH=4, E=0001 before edge 1, AUTO=0 -> Q[0] low in low phases 1..n while E=1, Q[3:1] constant 1; E=0 at edge 5 -> no Q[0] pulse from low phase 5.
REQ-029 SHALL: AUTO[0]=1, IDLE_CNT=3, E[0] 1->0 sampled at edge 10 -> Q[0] pulses in low phases 10,11,12, none at 13; ACTIVE[0] falls after edge 13.
REQ-030 SHALL: AUTO=1, IDLE_CNT=4, E drops at edge 10, reasserts at edge 12 -> continuous pulses, state ON after edge 12, no gap.
REQ-031 SHALL: TE=1 at edge 3 with E=0 -> all four Q pulse from low phase 3; ACTIVE=0000, BUSY=0; TE=0 at edge 6 -> Q held 1 from low phase 6.
REQ-032 SHALL: RST pulse mid-DRAIN (cnt=2) during CLKN low -> Q[0] high immediately, ACTIVE=0, no further pulses until E re-sampled 1.
REQ-033 SHALL: IDLE_CNT=0 with AUTO=1 -> behaves as AUTO=0 (no extra pulse); IDLE_CNT=15 (max) -> exactly 15 extra pulses.
